capture_alarm_timer: RTL and testbench

- Timer DUT driven by the timer_bfm/tester environment; responder end of the start/capture/alarm protocol.
- Rising edge on start begins counting clock cycles; each capture rising edge latches the elapsed count.
- Optional alarm strobe fires a programmed number of cycles after start.
- Sits between the external pulse sources and the host status registers.

---
 rtl/capture_alarm_timer_pkg.sv | 26 ++
 rtl/capture_alarm_timer_if.sv | 40 ++++
 rtl/capture_alarm_timer_pulse_edge_det.sv | 44 ++++
 rtl/capture_alarm_timer.sv | 159 +++++++++++++++
 tb/tb_capture_alarm_timer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/capture_alarm_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : capture_alarm_timer_pkg
// Brief    : Shared types, default widths and a saturating-increment helper
//            for the capture/alarm timer.
// Revision : 1.0 - initial release
// ============================================================================
package capture_alarm_timer_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RUNNING = 1'b1
  } timer_state_t;

  localparam int c_cnt_w_default     = 32;
  localparam int c_cap_cnt_w_default = 8;

  // Increment value by one, holding at the all-ones value of a width-bit field.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
    logic [63:0] max_v;
    max_v = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_v) ? max_v : (value + 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/capture_alarm_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : capture_alarm_timer_if
// Brief    : Start/capture/alarm control and status bundle between the pulse
//            sources (master) and the timer (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface capture_alarm_timer_if
  import capture_alarm_timer_pkg::*;
#(
  parameter int CNT_W     = c_cnt_w_default,
  parameter int CAP_CNT_W = c_cap_cnt_w_default
);
  logic                 start_i;
  logic                 capture_i;
  logic                 rst_capture_i;
  logic                 alarm_en_i;
  logic [CNT_W-1:0]     alarm_time_i;
  logic                 running_o;
  logic [CNT_W-1:0]     count_o;
  logic [CNT_W-1:0]     capture_value_o;
  logic                 capture_valid_o;
  logic                 capture_pulse_o;
  logic [CAP_CNT_W-1:0] capture_cnt_o;
  logic                 overflow_o;
  logic                 alarm_o;

  modport master (
    output start_i, capture_i, rst_capture_i, alarm_en_i, alarm_time_i,
    input  running_o, count_o, capture_value_o, capture_valid_o,
           capture_pulse_o, capture_cnt_o, overflow_o, alarm_o
  );

  modport slave (
    input  start_i, capture_i, rst_capture_i, alarm_en_i, alarm_time_i,
    output running_o, count_o, capture_value_o, capture_valid_o,
           capture_pulse_o, capture_cnt_o, overflow_o, alarm_o
  );
endinterface
`default_nettype wire

// File: rtl/capture_alarm_timer_pulse_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : capture_alarm_timer_pulse_edge_det
// Brief    : Optional 2-flop synchronizer followed by a rising-edge strobe.
//            Macro TIMER_INPUT_SYNC_EN inserts the synchronizer (+2 clk).
// Revision : 1.0 - initial release
// ============================================================================
module capture_alarm_timer_pulse_edge_det (
  input  logic clk,
  input  logic areset_n,
  input  logic sreset,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o
);

  logic prev_q;

`ifdef TIMER_INPUT_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer for an input that may be asynchronous to clk
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n)   sync_q <= '0;
    else if (sreset) sync_q <= '0;
    else             sync_q <= {sync_q[0], sig_i};
  end

  assign level_o = sync_q[1];
`else
  assign level_o = sig_i;
`endif

  // Previous-cycle history for rising-edge detection
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n)   prev_q <= 1'b0;
    else if (sreset) prev_q <= 1'b0;
    else             prev_q <= level_o;
  end

  assign rise_o = level_o & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/capture_alarm_timer.sv
`default_nettype none
// ============================================================================
// Module   : capture_alarm_timer
// Brief    : Elapsed-cycle timer started by a start edge; capture edges latch
//            the elapsed count; optional one-shot alarm after a programmed
//            delay. Macro TIMER_INPUT_SYNC_EN adds input synchronizers.
// Revision : 1.0 - initial release
// ============================================================================
module capture_alarm_timer
  import capture_alarm_timer_pkg::*;
#(
  parameter int CNT_W     = c_cnt_w_default,
  parameter int CAP_CNT_W = c_cap_cnt_w_default
) (
  input  logic                   clk,
  input  logic                   areset_n,
  input  logic                   sreset,
  capture_alarm_timer_if.slave   bus
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  timer_state_t         state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     cap_val_q, cap_val_d;
  logic                 cap_valid_q, cap_valid_d;
  logic                 cap_pulse_q, cap_pulse_d;
  logic [CAP_CNT_W-1:0] cap_cnt_q, cap_cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 armed_q, armed_d;
  logic [CNT_W-1:0]     atime_q, atime_d;
  logic                 alarm_q, alarm_d;

  logic w_start_rise, w_start_lvl;
  logic w_cap_rise, w_cap_lvl;
  logic w_rstc_rise, w_rstc_lvl;
  logic w_unused;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [CAP_CNT_W-1:0] w_cap_inc;

  capture_alarm_timer_pulse_edge_det u_start_det (
    .clk(clk), .areset_n(areset_n), .sreset(sreset),
    .sig_i(bus.start_i), .level_o(w_start_lvl), .rise_o(w_start_rise)
  );

  capture_alarm_timer_pulse_edge_det u_cap_det (
    .clk(clk), .areset_n(areset_n), .sreset(sreset),
    .sig_i(bus.capture_i), .level_o(w_cap_lvl), .rise_o(w_cap_rise)
  );

  capture_alarm_timer_pulse_edge_det u_rstc_det (
    .clk(clk), .areset_n(areset_n), .sreset(sreset),
    .sig_i(bus.rst_capture_i), .level_o(w_rstc_lvl), .rise_o(w_rstc_rise)
  );

  // rst_capture acts on level; start/capture act on edges
  assign w_unused  = ^{w_start_lvl, w_cap_lvl, w_rstc_rise};
  assign w_cnt_inc = CNT_W'(sat_inc(64'(count_q), CNT_W));
  assign w_cap_inc = CAP_CNT_W'(sat_inc(64'(cap_cnt_q), CAP_CNT_W));

  // State register
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state: reset/rst_capture force IDLE, any start edge (re)starts
  always_comb begin
    state_d = state_q;
    if (sreset || w_rstc_lvl) state_d = IDLE;
    else if (w_start_rise)    state_d = RUNNING;
  end

  // Datapath next values: priority sreset > rst_capture > start > run/capture
  always_comb begin
    count_d     = count_q;
    cap_val_d   = cap_val_q;
    cap_valid_d = cap_valid_q;
    cap_pulse_d = 1'b0;
    cap_cnt_d   = cap_cnt_q;
    ovf_d       = ovf_q;
    armed_d     = armed_q;
    atime_d     = atime_q;
    alarm_d     = 1'b0;
    if (sreset) begin
      count_d     = '0;
      cap_val_d   = '0;
      cap_valid_d = 1'b0;
      cap_cnt_d   = '0;
      ovf_d       = 1'b0;
      armed_d     = 1'b0;
      atime_d     = '0;
    end else if (w_rstc_lvl) begin
      count_d     = '0;
      cap_val_d   = '0;
      cap_valid_d = 1'b0;
      cap_cnt_d   = '0;
      ovf_d       = 1'b0;
      armed_d     = 1'b0;
    end else if (w_start_rise) begin
      // capture_value is deliberately held across a restart
      count_d     = '0;
      cap_valid_d = 1'b0;
      cap_cnt_d   = '0;
      ovf_d       = 1'b0;
      armed_d     = bus.alarm_en_i && (bus.alarm_time_i != '0);
      atime_d     = bus.alarm_time_i;
    end else if (state_q == RUNNING) begin
      count_d = w_cnt_inc;
      if (w_cnt_inc == c_cnt_max) ovf_d = 1'b1;
      if (armed_q && (w_cnt_inc == atime_q)) begin
        alarm_d = 1'b1;
        armed_d = 1'b0;
      end
      if (w_cap_rise) begin
        cap_val_d   = w_cnt_inc;
        cap_valid_d = 1'b1;
        cap_pulse_d = 1'b1;
        cap_cnt_d   = w_cap_inc;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      count_q     <= '0;
      cap_val_q   <= '0;
      cap_valid_q <= 1'b0;
      cap_pulse_q <= 1'b0;
      cap_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      armed_q     <= 1'b0;
      atime_q     <= '0;
      alarm_q     <= 1'b0;
    end else begin
      count_q     <= count_d;
      cap_val_q   <= cap_val_d;
      cap_valid_q <= cap_valid_d;
      cap_pulse_q <= cap_pulse_d;
      cap_cnt_q   <= cap_cnt_d;
      ovf_q       <= ovf_d;
      armed_q     <= armed_d;
      atime_q     <= atime_d;
      alarm_q     <= alarm_d;
    end
  end

  assign bus.running_o       = (state_q == RUNNING);
  assign bus.count_o         = count_q;
  assign bus.capture_value_o = cap_val_q;
  assign bus.capture_valid_o = cap_valid_q;
  assign bus.capture_pulse_o = cap_pulse_q;
  assign bus.capture_cnt_o   = cap_cnt_q;
  assign bus.overflow_o      = ovf_q;
  assign bus.alarm_o         = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_capture_alarm_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_alarm_timer
// Brief    : Drives a 32-bit and an 8-bit timer with the same stimulus and
//            checks both against an event-based model every cycle, plus
//            directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_capture_alarm_timer;

  localparam int CLKPERIOD_NS = 10;

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic        sreset = 1'b0;
  logic        start = 1'b0;
  logic        capture = 1'b0;
  logic        rstc = 1'b0;
  logic        alarm_en = 1'b0;
  logic [31:0] alarm_time = '0;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #(CLKPERIOD_NS/2) clk = ~clk;

  capture_alarm_timer_if #(.CNT_W(32), .CAP_CNT_W(8)) if32 ();
  capture_alarm_timer_if #(.CNT_W(8),  .CAP_CNT_W(8)) if8 ();

  assign if32.start_i       = start;
  assign if32.capture_i     = capture;
  assign if32.rst_capture_i = rstc;
  assign if32.alarm_en_i    = alarm_en;
  assign if32.alarm_time_i  = alarm_time;
  assign if8.start_i        = start;
  assign if8.capture_i      = capture;
  assign if8.rst_capture_i  = rstc;
  assign if8.alarm_en_i     = alarm_en;
  assign if8.alarm_time_i   = alarm_time[7:0];

  capture_alarm_timer #(.CNT_W(32), .CAP_CNT_W(8)) u_dut32 (
    .clk(clk), .areset_n(areset_n), .sreset(sreset), .bus(if32.slave)
  );
  capture_alarm_timer #(.CNT_W(8), .CAP_CNT_W(8)) u_dut8 (
    .clk(clk), .areset_n(areset_n), .sreset(sreset), .bus(if8.slave)
  );

  // ---------------- event model: records when things happened ----------------
  longint e_cyc = 0;        // clock edges seen
  longint m_n = 0;          // edge of the last start
  bit     m_run = 0;
  longint m_capraw = 0;     // unsaturated elapsed count of last capture
  bit     m_valid = 0;
  int     m_ncap = 0;
  longint m_last_cap = -1;  // edge of the last accepted capture
  bit     m_aen = 0;
  longint m_atime = 0;
  bit     p_start = 0, p_cap = 0;

  always @(posedge clk or negedge areset_n) begin
    if (!areset_n || sreset) begin
      m_run = 0; m_capraw = 0; m_valid = 0; m_ncap = 0; m_last_cap = -1;
      m_aen = 0; m_atime = 0; p_start = 0; p_cap = 0;
      if (areset_n) e_cyc++;
    end else begin
      bit rs, rc;
      e_cyc++;
      rs = start && !p_start;
      rc = capture && !p_cap;
      p_start = start;
      p_cap   = capture;
      if (rstc) begin
        m_run = 0; m_capraw = 0; m_valid = 0; m_ncap = 0;
      end else if (rs) begin
        m_run = 1; m_n = e_cyc; m_valid = 0; m_ncap = 0;
        m_aen = alarm_en; m_atime = longint'(alarm_time);
      end else if (rc && m_run) begin
        m_capraw = e_cyc - m_n; m_valid = 1; m_ncap++; m_last_cap = e_cyc;
      end
    end
  end

  function automatic longint lmin(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        longint mx, d, t;
        string  p;
        mx = (k == 0) ? 64'hFFFF_FFFF : 64'd255;
        t  = (k == 0) ? m_atime : (m_atime & 64'd255);
        d  = e_cyc - m_n;
        p  = (k == 0) ? "w32" : "w8";
        cmp({p, ".running"}, (k == 0) ? 64'(if32.running_o) : 64'(if8.running_o), 64'(m_run));
        cmp({p, ".count"}, (k == 0) ? 64'(if32.count_o) : 64'(if8.count_o),
            m_run ? lmin(d, mx) : 0);
        cmp({p, ".overflow"}, (k == 0) ? 64'(if32.overflow_o) : 64'(if8.overflow_o),
            64'(m_run && (d >= mx)));
        cmp({p, ".cap_value"}, (k == 0) ? 64'(if32.capture_value_o) : 64'(if8.capture_value_o),
            lmin(m_capraw, mx));
        cmp({p, ".cap_valid"}, (k == 0) ? 64'(if32.capture_valid_o) : 64'(if8.capture_valid_o),
            64'(m_valid));
        cmp({p, ".cap_pulse"}, (k == 0) ? 64'(if32.capture_pulse_o) : 64'(if8.capture_pulse_o),
            64'(m_last_cap == e_cyc));
        cmp({p, ".cap_cnt"}, (k == 0) ? 64'(if32.capture_cnt_o) : 64'(if8.capture_cnt_o),
            lmin(m_ncap, 255));
        cmp({p, ".alarm"}, (k == 0) ? 64'(if32.alarm_o) : 64'(if8.alarm_o),
            64'(m_run && m_aen && (t != 0) && (d == t)));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the negedge right after the start edge N
  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_capture();
    capture = 1'b1;
    tick(1);
    capture = 1'b0;
  endtask

  initial begin
    int g, npulse;
    tick(3);
    areset_n = 1'b1;
    chk_en   = 1'b1;
    cmp("reset.running", 64'(if32.running_o), 0);
    cmp("reset.count", 64'(if32.count_o), 0);
    cmp("reset.cap_valid", 64'(if32.capture_valid_o), 0);

    // capture while idle is ignored
    do_capture();
    cmp("idle_cap.pulse", 64'(if32.capture_pulse_o), 0);
    cmp("idle_cap.valid", 64'(if32.capture_valid_o), 0);
    tick(1);

    // random intervals
    for (int i = 0; i < 100; i++) begin
      g = int'($urandom_range(1, 600));
      do_start();
      tick(g - 1);
      do_capture();
      cmp("rand.value", 64'(if32.capture_value_o), 64'(g));
      cmp("rand.valid", 64'(if32.capture_valid_o), 1);
      cmp("rand.pulse", 64'(if32.capture_pulse_o), 1);
      cmp("rand.cnt", 64'(if32.capture_cnt_o), 1);
      tick(1);
      cmp("rand.pulse_once", 64'(if32.capture_pulse_o), 0);
    end

    // fixed 1234 interval
    do_start();
    tick(1233);
    do_capture();
    cmp("c1234.value", 64'(if32.capture_value_o), 1234);
    cmp("c1234.w8_value", 64'(if8.capture_value_o), 255);

    // double capture
    do_start();
    tick(99);
    do_capture();
    cmp("dbl.first", 64'(if32.capture_value_o), 100);
    tick(49);
    do_capture();
    cmp("dbl.second", 64'(if32.capture_value_o), 150);
    cmp("dbl.cnt", 64'(if32.capture_cnt_o), 2);
    cmp("dbl.running", 64'(if32.running_o), 1);

    // rst_capture mid-run, then a fresh measurement
    do_start();
    tick(49);
    rstc = 1'b1;
    tick(1);
    rstc = 1'b0;
    cmp("rstc.value", 64'(if32.capture_value_o), 0);
    cmp("rstc.valid", 64'(if32.capture_valid_o), 0);
    cmp("rstc.cnt", 64'(if32.capture_cnt_o), 0);
    cmp("rstc.running", 64'(if32.running_o), 0);
    cmp("rstc.count", 64'(if32.count_o), 0);
    do_start();
    tick(180);
    do_capture();
    cmp("rstc.after", 64'(if32.capture_value_o), 181);

    // alarm at 500
    alarm_en   = 1'b1;
    alarm_time = 32'd500;
    do_start();
    tick(499);
    cmp("alarm.pre_count", 64'(if32.count_o), 499);
    cmp("alarm.pre", 64'(if32.alarm_o), 0);
    tick(1);
    cmp("alarm.count", 64'(if32.count_o), 500);
    cmp("alarm.fire", 64'(if32.alarm_o), 1);
    tick(1);
    cmp("alarm.post", 64'(if32.alarm_o), 0);

    // alarm_time 0 never fires
    alarm_time = 32'd0;
    do_start();
    npulse = 0;
    for (int i = 0; i < 600; i++) begin
      tick(1);
      if (if32.alarm_o || if8.alarm_o) npulse++;
    end
    cmp("alarm0.none", 64'(npulse), 0);
    alarm_en = 1'b0;

    // start and capture on the same edge while running
    do_start();
    tick(300);
    cmp("simul.pre_count", 64'(if32.count_o), 300);
    start   = 1'b1;
    capture = 1'b1;
    tick(1);
    start   = 1'b0;
    capture = 1'b0;
    cmp("simul.count", 64'(if32.count_o), 0);
    cmp("simul.value", 64'(if32.capture_value_o), 181);
    cmp("simul.pulse", 64'(if32.capture_pulse_o), 0);
    cmp("simul.running", 64'(if32.running_o), 1);
    tick(2);

    // synchronous reset
    do_start();
    tick(20);
    sreset = 1'b1;
    tick(1);
    sreset = 1'b0;
    cmp("srst.running", 64'(if32.running_o), 0);
    cmp("srst.count", 64'(if32.count_o), 0);
    cmp("srst.value", 64'(if32.capture_value_o), 0);

    // saturation of the 8-bit instance, then asynchronous reset mid-cycle
    do_start();
    tick(299);
    do_capture();
    cmp("sat.w8_value", 64'(if8.capture_value_o), 255);
    cmp("sat.w8_ovf", 64'(if8.overflow_o), 1);
    cmp("sat.w8_running", 64'(if8.running_o), 1);
    cmp("sat.w32_value", 64'(if32.capture_value_o), 300);
    cmp("sat.w32_ovf", 64'(if32.overflow_o), 0);
    tick(3);
    #(CLKPERIOD_NS/4);
    areset_n = 1'b0;
    #1;
    cmp("arst.w8_count", 64'(if8.count_o), 0);
    cmp("arst.w8_value", 64'(if8.capture_value_o), 0);
    cmp("arst.w8_ovf", 64'(if8.overflow_o), 0);
    cmp("arst.w8_running", 64'(if8.running_o), 0);
    cmp("arst.w32_count", 64'(if32.count_o), 0);
    cmp("arst.w32_cnt", 64'(if32.capture_cnt_o), 0);
    tick(2);
    areset_n = 1'b1;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
